vme_a24_slave: RTL

VME_A24_SLAVE -- requirements
Module: vme_a24_slave

---
 rtl/vme_a24_slave.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/vme_a24_slave.sv
// ============================================================================
// vme_a24_slave : VME A24/D32 slave bridged to a Wishbone classic master port
// Revision: 1.0
// ============================================================================
`default_nettype none

module vme_a24_slave #(
    parameter int g_timeout     = 255,
    parameter int g_sync_stages = 2
) (
    input  logic        clk_sys_i,
    input  logic        rst_a_i,
    input  logic        enable_i,
    input  logic [4:0]  base_addr_i,
    input  logic        vme_as_n_i,
    input  logic [1:0]  vme_ds_n_i,
    input  logic        vme_write_n_i,
    input  logic        vme_lword_n_i,
    input  logic [5:0]  vme_am_i,
    input  logic [22:0] vme_addr_i,
    input  logic [31:0] vme_data_i,
    output logic [31:0] vme_data_o,
    output logic        vme_data_oe_o,
    output logic        vme_dtack_n_o,
    output logic        vme_dtack_oe_o,
    output logic        vme_berr_n_o,
    output logic [16:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int                 c_tmo_w    = $clog2(g_timeout + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(g_timeout - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_WB_REQ   = 3'd2,
        S_WB_WAIT  = 3'd3,
        S_RESPOND  = 3'd4,
        S_WAIT_END = 3'd5
    } state_t;

    logic [g_sync_stages-1:0] r_as_sh, r_wr_sh, r_vld;
    logic [1:0]               r_ds_sh [g_sync_stages];
    logic                     r_as_prev, r_armed;
    logic                     w_as_s, w_wr_s, w_as_fall, w_ds_lo, w_ds_hi, w_claim;

    state_t             r_state, w_state;
    logic [5:0]         r_am, w_am;
    logic [22:0]        r_addr, w_addr;
    logic               r_lword_n, w_lword_n, r_write_n, w_write_n, r_err, w_err;
    logic [c_tmo_w-1:0] r_tmo, w_tmo;
    logic               r_cyc, w_cyc, r_we, w_we;
    logic [3:0]         r_sel, w_sel;
    logic [16:0]        r_adr, w_adr;
    logic [31:0]        r_wdat, w_wdat, r_rdat, w_rdat;
    logic               r_dtack_n, w_dtack_n, r_berr_n, w_berr_n;
    logic               r_dtack_oe, w_dtack_oe, r_data_oe, w_data_oe;

    assign w_as_s    = r_as_sh[g_sync_stages-1];
    assign w_wr_s    = r_wr_sh[g_sync_stages-1];
    assign w_ds_lo   = (r_ds_sh[g_sync_stages-1] == 2'b00);
    assign w_ds_hi   = (r_ds_sh[g_sync_stages-1] == 2'b11);
    // Armed only once a genuine high AS_n has crossed the synchronizer after reset
    assign w_as_fall = r_armed & r_as_prev & ~w_as_s;
    assign w_claim   = enable_i && ((r_am == 6'h39) || (r_am == 6'h3D)) &&
                       (r_addr[22:18] == base_addr_i);

    always_ff @(posedge clk_sys_i or posedge rst_a_i) begin
        if (rst_a_i) begin
            r_as_sh   <= '1;
            r_wr_sh   <= '1;
            r_vld     <= '0;
            for (int i = 0; i < g_sync_stages; i++) r_ds_sh[i] <= 2'b11;
            r_as_prev <= 1'b1;
            r_armed   <= 1'b0;
        end else begin
            r_as_sh[0] <= vme_as_n_i;
            r_wr_sh[0] <= vme_write_n_i;
            r_ds_sh[0] <= vme_ds_n_i;
            r_vld[0]   <= 1'b1;
            for (int i = 1; i < g_sync_stages; i++) begin
                r_as_sh[i] <= r_as_sh[i-1];
                r_wr_sh[i] <= r_wr_sh[i-1];
                r_ds_sh[i] <= r_ds_sh[i-1];
                r_vld[i]   <= r_vld[i-1];
            end
            r_as_prev <= w_as_s;
            if (r_vld[g_sync_stages-1] && w_as_s) r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state = r_state;   w_am = r_am;         w_addr = r_addr;
        w_lword_n = r_lword_n; w_write_n = r_write_n; w_err = r_err;
        w_tmo = r_tmo;       w_cyc = r_cyc;       w_we = r_we;
        w_sel = r_sel;       w_adr = r_adr;       w_wdat = r_wdat;
        w_rdat = r_rdat;     w_dtack_n = r_dtack_n; w_berr_n = r_berr_n;
        w_dtack_oe = r_dtack_oe; w_data_oe = r_data_oe;
        if (w_as_s && (r_state != S_IDLE) && (r_state != S_WAIT_END)) begin
            w_state = S_IDLE;  w_cyc = 1'b0;  w_we = 1'b0;  w_sel = 4'h0;
            w_dtack_n = 1'b1;  w_berr_n = 1'b1;
            w_dtack_oe = 1'b0; w_data_oe = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_as_fall) begin
                    w_am = vme_am_i;  w_addr = vme_addr_i;  w_lword_n = vme_lword_n_i;
                    w_write_n = w_wr_s;  w_err = 1'b0;  w_state = S_DECODE;
                end
                S_DECODE: if (!w_claim) begin
                    w_state = S_WAIT_END;
                end else if (w_ds_lo) begin
                    w_wdat = vme_data_i;
                    if (!r_lword_n && !r_addr[0]) w_state = S_WB_REQ;
                    else begin w_err = 1'b1; w_state = S_RESPOND; end
                end
                S_WB_REQ: begin
                    w_cyc = 1'b1;  w_we = ~r_write_n;  w_sel = 4'hF;
                    w_adr = r_addr[17:1];  w_tmo = '0;  w_state = S_WB_WAIT;
                end
                S_WB_WAIT: if (wb_err_i || wb_ack_i || (r_tmo == c_tmo_last)) begin
                    w_cyc = 1'b0;  w_we = 1'b0;  w_sel = 4'h0;  w_state = S_RESPOND;
                    if (wb_ack_i && !wb_err_i) begin
                        if (r_write_n) w_rdat = wb_dat_i;
                        w_data_oe = r_write_n;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
                S_RESPOND: if (!r_dtack_oe) begin
                    w_dtack_oe = 1'b1;
                    if (r_err) w_berr_n = 1'b0;
                    else       w_dtack_n = 1'b0;
                end else if (w_ds_hi) begin
                    // DTACK enable lingers one cycle so the line is driven high
                    w_dtack_n = 1'b1;  w_berr_n = 1'b1;  w_data_oe = 1'b0;
                    w_state = S_WAIT_END;
                end
                S_WAIT_END: begin
                    w_dtack_oe = 1'b0;
                    if (w_as_s) w_state = S_IDLE;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_a_i) begin
        if (rst_a_i) begin
            r_state <= S_IDLE;  r_am <= '0;  r_addr <= '0;  r_lword_n <= 1'b1;
            r_write_n <= 1'b1;  r_err <= 1'b0;  r_tmo <= '0;
            r_cyc <= 1'b0;  r_we <= 1'b0;  r_sel <= 4'h0;  r_adr <= '0;
            r_wdat <= '0;  r_rdat <= '0;  r_dtack_n <= 1'b1;  r_berr_n <= 1'b1;
            r_dtack_oe <= 1'b0;  r_data_oe <= 1'b0;
        end else begin
            r_state <= w_state;  r_am <= w_am;  r_addr <= w_addr;  r_lword_n <= w_lword_n;
            r_write_n <= w_write_n;  r_err <= w_err;  r_tmo <= w_tmo;
            r_cyc <= w_cyc;  r_we <= w_we;  r_sel <= w_sel;  r_adr <= w_adr;
            r_wdat <= w_wdat;  r_rdat <= w_rdat;  r_dtack_n <= w_dtack_n;  r_berr_n <= w_berr_n;
            r_dtack_oe <= w_dtack_oe;  r_data_oe <= w_data_oe;
        end
    end

    assign wb_cyc_o       = r_cyc;
    assign wb_stb_o       = r_cyc;
    assign wb_we_o        = r_we;
    assign wb_sel_o       = r_sel;
    assign wb_adr_o       = r_adr;
    assign wb_dat_o       = r_wdat;
    assign vme_data_o     = r_rdat;
    assign vme_data_oe_o  = r_data_oe;
    assign vme_dtack_n_o  = r_dtack_n;
    assign vme_berr_n_o   = r_berr_n;
    assign vme_dtack_oe_o = r_dtack_oe;

endmodule

`default_nettype wire
